// File: rtl/neuron_tdm_if.sv
// Bus between the TDM neuron scheduler and its current source, spike/AER sink and step controller.
// The master side drives step control, currents and spike_ready; the slave side is the scheduler.
interface neuron_tdm_if #(
  parameter int N_NEURONS = 8,
  parameter int WIDTH     = 8
);
  localparam int IDXW = $clog2(N_NEURONS);

  logic             step_start;
  logic             clear;
  logic [WIDTH-1:0] threshold;
  logic [IDXW-1:0]  cur_idx;
  logic [WIDTH-1:0] cur_in;
  logic             spike_valid;
  logic             spike_ready;
  logic [IDXW-1:0]  spike_addr;
  logic             busy;
  logic             step_done;

  modport master (
    output step_start, clear, threshold, cur_in, spike_ready,
    input  cur_idx, spike_valid, spike_addr, busy, step_done
  );

  modport slave (
    input  step_start, clear, threshold, cur_in, spike_ready,
    output cur_idx, spike_valid, spike_addr, busy, step_done
  );
endinterface

// File: rtl/neuron_tdm_scheduler.sv
// Time-multiplexed integrate-and-fire controller: one shared accumulate/leak/threshold datapath
// walks all neurons each timestep and emits spikes as address-events.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for step_start; clear zeroes all membranes
// S_UPDATE | integrate neuron idx (one neuron per cycle)
// S_EMIT   | spike for neuron idx held on the AER port until accepted
// S_DONE   | step_done pulse, return to idle
module neuron_tdm_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int WIDTH     = 8,
  parameter int LEAK      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  neuron_tdm_if.slave  bus
);
  localparam int              IDXW     = $clog2(N_NEURONS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);
  localparam logic [WIDTH-1:0] LEAK_W  = WIDTH'(LEAK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] thr_q;
  logic [WIDTH-1:0] mem [N_NEURONS];
  logic [IDXW-1:0]  spike_addr_q;
  logic             spike_valid_q;
  logic             busy_q;
  logic             step_done_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat;
  logic [WIDTH-1:0] v;
  logic             last;

  // Sum is one bit wider so overflow can be detected and clamped before the leak.
  always_comb begin
    sum  = {1'b0, mem[idx]} + {1'b0, bus.cur_in};
    sat  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    v    = (sat > LEAK_W) ? (sat - LEAK_W) : '0;
    last = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      thr_q         <= '0;
      spike_addr_q  <= '0;
      spike_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      step_done_q   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
    end else begin
      step_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.clear) begin
            for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
          end else if (bus.step_start) begin
            thr_q  <= bus.threshold;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (v >= thr_q) begin
            mem[idx]      <= '0;
            spike_addr_q  <= idx;
            spike_valid_q <= 1'b1;
            state         <= S_EMIT;
          end else begin
            mem[idx] <= v;
            if (last) begin
              step_done_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        S_EMIT: begin
          if (spike_valid_q && bus.spike_ready) begin
            spike_valid_q <= 1'b0;
            if (last) begin
              step_done_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              idx   <= idx + IDXW'(1);
              state <= S_UPDATE;
            end
          end
        end
        S_DONE: begin
          idx    <= '0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cur_idx     = idx;
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_addr  = spike_addr_q;
  assign bus.busy        = busy_q;
  assign bus.step_done   = step_done_q;
endmodule

// File: tb/tb_neuron_tdm_scheduler.sv
// Bench for neuron_tdm_scheduler: table of directed timesteps, random timesteps against an
// arithmetic membrane model, and hand-written clear/reset corner cases.
module tb_neuron_tdm_scheduler;
  localparam int N    = 8;
  localparam int W    = 8;
  localparam int LEAK = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  neuron_tdm_if #(.N_NEURONS(N), .WIDTH(W)) bus ();
  neuron_tdm_scheduler #(.N_NEURONS(N), .WIDTH(W), .LEAK(LEAK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [W-1:0] cur_vals [N];
  assign bus.cur_in = cur_vals[bus.cur_idx];

  int model_mem [N];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]        thr;
    logic [N-1:0][7:0] cur;
    int                stall;
    bit                noise;
    logic [7:0]        mask;
  } vec_t;
  vec_t tbl [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: saturating add, leak floored at zero, fire-and-reset, neurons in index order.
  function automatic logic [7:0] model_step(input int thr);
    logic [7:0] m;
    int s, v;
    m = '0;
    for (int n = 0; n < N; n++) begin
      s = model_mem[n] + int'(cur_vals[n]);
      if (s > 255) s = 255;
      v = (s > LEAK) ? s - LEAK : 0;
      if (v >= thr) begin
        m[n] = 1'b1;
        model_mem[n] = 0;
      end else begin
        model_mem[n] = v;
      end
    end
    return m;
  endfunction

  function automatic bit mem_matches();
    for (int i = 0; i < N; i++)
      if (dut.mem[i] !== model_mem[i][W-1:0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pick_stall(input int s);
    return (s >= 0) ? s : int'($urandom_range(0, 3));
  endfunction

  task automatic run_step(input logic [7:0] thr, input int stall, input bit noise,
                          output logic [7:0] obs);
    logic [7:0] expm;
    int exp_q [$];
    int cyc, stalls, stall_left, nexp;
    bit done_seen, busy_ok, addr_ok;
    expm = model_step(int'(thr));
    nexp = $countones(expm);
    for (int i = 0; i < N; i++) if (expm[i]) exp_q.push_back(i);
    obs = '0;
    bus.threshold  = thr;
    bus.step_start = 1'b1;
    tick();
    bus.step_start = 1'b0;
    cyc = 1; stalls = 0; done_seen = 0; busy_ok = 1; addr_ok = 1;
    stall_left = pick_stall(stall);
    while (!done_seen && cyc < 300) begin
      if (noise) begin
        bus.threshold  = 8'($urandom);
        bus.step_start = ($urandom_range(0, 3) == 0);
        bus.clear      = ($urandom_range(0, 3) == 0);
      end
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (bus.step_done === 1'b1) begin
        done_seen      = 1;
        bus.step_start = 1'b0;
        bus.clear      = 1'b0;
        bus.spike_ready = 1'b1;
        check("step_latency", cyc, N + 1 + nexp + stalls);
      end else if (bus.spike_valid === 1'b1) begin
        if (stall_left > 0) begin
          bus.spike_ready = 1'b0;
          stall_left--;
          stalls++;
          if (exp_q.size() == 0 || int'(bus.spike_addr) != exp_q[0]) addr_ok = 0;
        end else begin
          bus.spike_ready = 1'b1;
          check("spike_addr", int'(bus.spike_addr), (exp_q.size() > 0) ? exp_q.pop_front() : -1);
          obs[bus.spike_addr] = 1'b1;
          stall_left = pick_stall(stall);
        end
      end else begin
        bus.spike_ready = 1'($urandom);
      end
      tick();
      cyc++;
    end
    check("step_done_seen", done_seen, 1);
    check("spike_mask", int'(obs), int'(expm));
    check("busy_during_step", busy_ok, 1);
    check("addr_stable_stall", addr_ok, 1);
    check("busy_after_done", bus.busy, 0);
    check("mem_after_step", mem_matches(), 1);
  endtask

  task automatic add_vec(input int thr, input int all, input int ia, input int va,
                         input int ib, input int vb, input int stall, input bit noise,
                         input int mask);
    vec_t t;
    t.thr = 8'(thr);
    for (int i = 0; i < N; i++) t.cur[i] = 8'(all);
    if (ia >= 0) t.cur[ia] = 8'(va);
    if (ib >= 0) t.cur[ib] = 8'(vb);
    t.stall = stall;
    t.noise = noise;
    t.mask  = 8'(mask);
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] obs;
    bit ok, seen;

    rst_n = 1'b0;
    bus.step_start = 1'b0; bus.clear = 1'b0; bus.threshold = '0; bus.spike_ready = 1'b1;
    for (int i = 0; i < N; i++) begin cur_vals[i] = '0; model_mem[i] = 0; end
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_spike_valid", bus.spike_valid, 0);
    rst_n = 1'b1;
    tick();
    check("reset_busy", bus.busy, 0);
    check("reset_step_done", bus.step_done, 0);
    check("reset_spike_valid", bus.spike_valid, 0);
    check("reset_cur_idx", int'(bus.cur_idx), 0);
    check("reset_spike_addr", int'(bus.spike_addr), 0);
    check("reset_mem", mem_matches(), 1);

    // thr, all, idxA, valA, idxB, valB, stall, noise, expected spike mask
    add_vec(255, 0, -1, 0, -1, 0, 0, 1, 8'h00);
    add_vec(10, 4, -1, 0, -1, 0, 0, 0, 8'h00);
    add_vec(10, 4, -1, 0, -1, 0, 0, 1, 8'h00);
    add_vec(10, 4, -1, 0, -1, 0, 0, 0, 8'h00);
    add_vec(10, 4, -1, 0, -1, 0, -1, 1, 8'hFF);
    add_vec(255, 0, 2, 251, -1, 0, 0, 0, 8'h00);
    add_vec(254, 0, 2, 20, -1, 0, 0, 0, 8'h04);
    add_vec(255, 0, 2, 251, -1, 0, 0, 0, 8'h00);
    add_vec(255, 0, 2, 20, -1, 0, 0, 1, 8'h00);
    add_vec(253, 0, -1, 0, -1, 0, 0, 0, 8'h04);
    add_vec(20, 0, 0, 50, 5, 50, 4, 0, 8'h21);
    add_vec(0, 0, -1, 0, -1, 0, 1, 1, 8'hFF);

    foreach (tbl[k]) begin
      for (int i = 0; i < N; i++) cur_vals[i] = tbl[k].cur[i];
      run_step(tbl[k].thr, tbl[k].stall, tbl[k].noise, obs);
      check($sformatf("table_mask_%0d", k), int'(obs), int'(tbl[k].mask));
    end

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++)
        cur_vals[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 40));
      run_step(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)), -1, 1, obs);
      if (r % 10 == 9) begin
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < N; i++) model_mem[i] = 0;
        check("idle_clear_mem", mem_matches(), 1);
      end
    end

    for (int i = 0; i < N; i++) cur_vals[i] = 8'd10;
    run_step(8'd255, 0, 0, obs);
    bus.clear = 1'b1; bus.step_start = 1'b1; bus.threshold = '0;
    tick();
    bus.clear = 1'b0; bus.step_start = 1'b0;
    for (int i = 0; i < N; i++) model_mem[i] = 0;
    check("clear_wins_busy", bus.busy, 0);
    check("clear_wins_mem", mem_matches(), 1);
    tick();
    check("clear_wins_no_step", bus.busy | bus.step_done, 0);

    for (int i = 0; i < N; i++) cur_vals[i] = 8'd30;
    run_step(8'd255, 0, 0, obs);
    for (int i = 0; i < N; i++) cur_vals[i] = 8'd0;
    cur_vals[3] = 8'd40;
    bus.threshold = 8'd60; bus.spike_ready = 1'b0; bus.step_start = 1'b1;
    tick();
    bus.step_start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.spike_valid === 1'b1) seen = 1;
      else tick();
    end
    check("rst_wait_emit", seen, 1);
    check("rst_emit_addr", int'(bus.spike_addr), 3);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) model_mem[i] = 0;
    check("async_rst_valid", bus.spike_valid, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_addr", int'(bus.spike_addr), 0);
    check("async_rst_cur_idx", int'(bus.cur_idx), 0);
    check("async_rst_mem", mem_matches(), 1);
    tick();
    rst_n = 1'b1;
    bus.spike_ready = 1'b1;
    ok = 1;
    repeat (12) begin
      tick();
      if (bus.spike_valid !== 1'b0 || bus.step_done !== 1'b0 || bus.busy !== 1'b0) ok = 0;
    end
    check("post_rst_quiet", ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
